pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Parametrised pipeline-stage register for the 5-stage MIPS core: next generation of the
//   fixed 2x32-bit stage latch. Carries a DATA_W payload with valid/ready handshake, one-entry
//   skid buffer (full throughput, registered in_ready), stall, flush-to-NOP and a bubble
//   counter. Drop-in for IF/ID, ID/EX, EX/MEM, MEM/WB by setting DATA_W.
// PARAMETERS
//   DATA_W    64   payload width (e.g. {inst, PC+4} for IF/ID)
//   FLUSH_VAL 0    payload driven when stage empty/flushed (all-zero = MIPS NOP)
//   CNT_W     16   width of bubble counter
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   flush      in   1        kill all held entries (branch/jump/exception)
//   stall      in   1        hazard hold: blocks output transfer
//   in_valid   in   1        upstream payload valid
//   in_ready   out  1        stage can accept (registered)
//   in_data    in   DATA_W   upstream payload
//   out_valid  out  1        payload valid to next stage
//   out_ready  in   1        next stage can accept
//   out_data   out  DATA_W   payload to next stage
//   bubble_cnt out  CNT_W    cycles next stage was ready but got no valid data
// BEHAVIOUR
//   push = in_valid & in_ready;  pop = out_valid & out_ready & ~stall.
//   Storage: main reg (drives out_*) + skid reg. States: EMPTY, ONE (main), TWO (main+skid).
//   EMPTY: push -> ONE, main<=in_data.
//   ONE:   push&pop -> ONE, main<=in_data; push&~pop -> TWO, skid<=in_data;
//          pop&~push -> EMPTY, main<=FLUSH_VAL; neither -> hold.
//   TWO:   in_ready=0 (no push); pop -> ONE, main<=skid, skid<=FLUSH_VAL; else hold.
//   in_ready = (state != TWO), from a flop; no comb path from out_ready/stall to in_ready.
//   out_valid = (state != EMPTY); out_data = main reg; stall does not clear out_valid,
//     only blocks pop. out_data == FLUSH_VAL whenever out_valid=0.
//   Latency: in_data accepted at edge N appears on out_data after edge N; 1 beat/cycle
//     sustained when out_ready=1, stall=0.
//   Flush (priority over all but reset): next state EMPTY, main/skid <= FLUSH_VAL,
//     in_ready<=1; a push in the flush cycle is discarded; a pop in that cycle still
//     completes (downstream already sampled it).
//   Flush and stall together: flush wins.
//   bubble_cnt: +1 on each cycle with out_ready=1, stall=0, out_valid=0, flush=0;
//     saturates at 2^CNT_W-1, no wrap. Not cleared by flush.
//   Reset (sync, highest priority): state EMPTY, out_valid=0, in_ready=1,
//     out_data=FLUSH_VAL, skid=FLUSH_VAL, bubble_cnt=0. Mid-transfer reset drops all data.
//   Payload never altered; order strictly FIFO; no entry lost or duplicated.
// TESTING
//   1 Reset: hold reset 2 cycles -> out_valid=0, in_ready=1, out_data=0, bubble_cnt=0.
//   2 Streaming: in_valid=1 with data 1..8, out_ready=1 -> out_data 1..8 on consecutive
//     cycles, one cycle after acceptance, in_ready stays 1.
//   3 Backpressure: send A,B with out_ready=0 -> after B in_ready=0, out_data=A; raise
//     out_ready -> A then B delivered, in_ready=1 one cycle after A pops.
//   4 Stall: stall=1 for 3 cycles with entry X held -> out_data=X, out_valid=1 throughout,
//     no pop; release -> X popped once.
//   5 Flush in TWO with in_valid=1 data C -> next cycle out_valid=0, out_data=0,
//     in_ready=1, C never appears at output.
//   6 Bubbles: CNT_W=2, out_ready=1, in_valid=0 for 6 cycles -> bubble_cnt 1,2,3,3,3,3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer and flush-to-NOP; one cycle of latency.
// Sustains 1 beat/cycle; in_ready is a flop that drops only when main and skid are both full.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W    = 64,
  parameter logic [DATA_W-1:0]    FLUSH_VAL = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   main_q;
  logic [DATA_W-1:0]   skid_q;
  logic                in_ready_q;
  logic [CNT_W-1:0]    bubble_q;

  logic push;
  logic pop;
  logic bubble_inc;

  assign push       = in_valid & in_ready_q;
  assign pop        = out_valid & out_ready & ~stall;
  assign bubble_inc = out_ready & ~stall & ~out_valid & ~flush;

  assign in_ready   = in_ready_q;
  assign out_valid  = (state != EMPTY);
  assign out_data   = main_q;
  assign bubble_cnt = bubble_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      main_q     <= FLUSH_VAL;
      skid_q     <= FLUSH_VAL;
      in_ready_q <= 1'b1;
      bubble_q   <= '0;
    end else begin
      if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + 1'b1;
      end

      // Flush discards any push this cycle; a concurrent pop was already taken downstream.
      if (flush) begin
        state      <= EMPTY;
        main_q     <= FLUSH_VAL;
        skid_q     <= FLUSH_VAL;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              state  <= ONE;
              main_q <= in_data;
            end
            in_ready_q <= 1'b1;
          end
          ONE: begin
            if (push && pop) begin
              main_q     <= in_data;
              in_ready_q <= 1'b1;
            end else if (push) begin
              state      <= TWO;
              skid_q     <= in_data;
              in_ready_q <= 1'b0;
            end else if (pop) begin
              state      <= EMPTY;
              main_q     <= FLUSH_VAL;
              in_ready_q <= 1'b1;
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          TWO: begin
            if (pop) begin
              state      <= ONE;
              main_q     <= skid_q;
              skid_q     <= FLUSH_VAL;
              in_ready_q <= 1'b1;
            end else begin
              in_ready_q <= 1'b0;
            end
          end
          default: begin
            state      <= EMPTY;
            main_q     <= FLUSH_VAL;
            skid_q     <= FLUSH_VAL;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, stall, flush, bubble saturation.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              stall;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .DATA_W   (DATA_W),
    .FLUSH_VAL('0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    stall     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_bubble",    {30'd0, bubble_cnt}, 32'd0);
    reset = 1'b0;

    // Streaming 1..8
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DATA_W'(i);
      tick();
      check($sformatf("stream_data_%0d", i),  {16'd0, out_data},  32'(i));
      check($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream_rdy_%0d", i),   {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", {31'd0, out_valid}, 32'd0);
    check("stream_drain_data",  {16'd0, out_data},  32'd0);

    // Backpressure: A, B with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00AA;
    tick();
    check("bp_a_data", {16'd0, out_data}, 32'h00AA);
    check("bp_a_rdy",  {31'd0, in_ready}, 32'd1);
    in_data = 16'h00BB;
    tick();
    check("bp_b_rdy",  {31'd0, in_ready}, 32'd0);
    check("bp_b_data", {16'd0, out_data}, 32'h00AA);
    in_data = 16'h00CC;  // offered while full: must not be taken
    tick();
    check("bp_full_data", {16'd0, out_data}, 32'h00AA);
    check("bp_full_rdy",  {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_pop_a_data", {16'd0, out_data},  32'h00BB);
    check("bp_pop_a_rdy",  {31'd0, in_ready},  32'd1);
    check("bp_pop_a_vld",  {31'd0, out_valid}, 32'd1);
    tick();
    check("bp_pop_b_vld",  {31'd0, out_valid}, 32'd0);

    // Stall with X held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_data_%0d", i),  {16'd0, out_data},  32'h0055);
      check($sformatf("stall_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall_release_vld", {31'd0, out_valid}, 32'd0);
    tick();
    check("stall_once_data", {16'd0, out_data}, 32'd0);

    // Flush in TWO while C is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    check("fl_pre_rdy", {31'd0, in_ready}, 32'd0);
    flush   = 1'b1;
    stall   = 1'b1;
    in_data = 16'h00C0;
    tick();
    check("fl_vld",  {31'd0, out_valid}, 32'd0);
    check("fl_data", {16'd0, out_data},  32'd0);
    check("fl_rdy",  {31'd0, in_ready},  32'd1);
    flush     = 1'b0;
    stall     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("fl_post_vld",  {31'd0, out_valid}, 32'd0);
    check("fl_post_data", {16'd0, out_data},  32'd0);

    // Bubble counter from a fresh reset
    reset = 1'b1;
    tick();
    tick();
    check("bub_rst", {30'd0, bubble_cnt}, 32'd0);
    reset = 1'b0;
    flush = 1'b1;
    tick();
    check("bub_flush_noinc", {30'd0, bubble_cnt}, 32'd0);
    flush = 1'b0;
    stall = 1'b1;
    tick();
    check("bub_stall_noinc", {30'd0, bubble_cnt}, 32'd0);
    stall = 1'b0;
    begin
      logic [31:0] exp_bub [6];
      exp_bub = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
      for (int i = 0; i < 6; i++) begin
        tick();
        check($sformatf("bub_%0d", i), {30'd0, bubble_cnt}, exp_bub[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
